// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer with a req/ack memory handshake and a fetch timeout.
// Optional macro PC_ALIGN_CHECK_EN: adds misalign_o and a HALT state for unaligned next-PC values.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] pc_o,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] branch_target_i,
   input  logic        branch_taken_i,
   input  logic [31:0] jump_target_i,
   input  logic        jump_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        fetch_err_o
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic        misalign_o
`endif
);

   // state   | meaning
   // S_IDLE  | just out of reset, no request yet
   // S_REQ   | fetch request outstanding at pc_o
   // S_VALID | instr_o held for decode until consumed
   // S_HALT  | unaligned next PC seen (PC_ALIGN_CHECK_EN only)
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID
`ifdef PC_ALIGN_CHECK_EN
      ,
      S_HALT
`endif
   } state_t;

   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYC - 1);

   state_t      state, state_nxt;
   logic [7:0]  tmr, tmr_nxt;
   logic [31:0] next_pc_raw, pc_nxt;
   logic        pc_load, capture, err_nxt, misalign_set;

   always_comb begin
      if (jump_i)              next_pc_raw = jump_target_i;
      else if (branch_taken_i) next_pc_raw = branch_target_i;
      else                     next_pc_raw = pc_plus4_i;
   end

`ifdef PC_ALIGN_CHECK_EN
   assign pc_nxt = next_pc_raw;
`else
   assign pc_nxt = next_pc_raw & ~32'h3;
`endif

   // Timeout timer counts down from TIMEOUT_CYC-1; terminal count with no ack raises the error.
   always_comb begin
      state_nxt    = state;
      tmr_nxt      = tmr;
      pc_load      = 1'b0;
      capture      = 1'b0;
      err_nxt      = 1'b0;
      misalign_set = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_REQ;
         S_REQ: begin
            if (imem_ack_i) begin
               capture   = 1'b1;
               state_nxt = S_VALID;
               tmr_nxt   = TMR_LOAD;
            end else if (tmr == 8'd0) begin
               err_nxt = 1'b1;
               tmr_nxt = TMR_LOAD;
            end else begin
               tmr_nxt = tmr - 8'd1;
            end
         end
         S_VALID: begin
            if (!stall_i) begin
`ifdef PC_ALIGN_CHECK_EN
               if (pc_nxt[1:0] != 2'b00) begin
                  misalign_set = 1'b1;
                  state_nxt    = S_HALT;
               end else begin
                  pc_load   = 1'b1;
                  state_nxt = S_REQ;
               end
`else
               pc_load   = 1'b1;
               state_nxt = S_REQ;
`endif
            end
         end
`ifdef PC_ALIGN_CHECK_EN
         S_HALT: state_nxt = S_HALT;
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         pc_o        <= RESET_PC;
         instr_o     <= 32'h0;
         fetch_err_o <= 1'b0;
         tmr         <= TMR_LOAD;
      end else begin
         state       <= state_nxt;
         tmr         <= tmr_nxt;
         fetch_err_o <= err_nxt;
         if (pc_load) pc_o <= pc_nxt;
         if (capture) instr_o <= imem_data_i;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)             misalign_o <= 1'b0;
      else if (misalign_set) misalign_o <= 1'b1;
   end
`endif

   assign imem_req_o    = (state == S_REQ);
   assign imem_addr_o   = pc_o;
   assign instr_valid_o = (state == S_VALID);

endmodule
